// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: KSA state encoding, S-box size and key-byte selection.
package rc4_pkg;

   localparam int S_SIZE             = 256;
   localparam int DEFAULT_KEY_LENGTH = 3;
   localparam int KEY_MAX_BYTES      = 32;
   localparam int KEY_MAX_WIDTH      = 8 * KEY_MAX_BYTES;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_SI   = 3'd1,
      WAIT_SI = 3'd2,
      RD_SJ   = 3'd3,
      WAIT_SJ = 3'd4,
      WR_SI   = 3'd5,
      WR_SJ   = 3'd6,
      DONE    = 3'd7
   } ksa_state_t;

   // Byte idx of a big-endian n_bytes-long key that sits right-aligned in key.
   function automatic logic [7:0] key_byte_select(
      input logic [KEY_MAX_WIDTH-1:0] key,
      input logic [7:0]               idx,
      input int                       n_bytes
   );
      logic [KEY_MAX_WIDTH-1:0] shifted;
      shifted = key >> (8 * (n_bytes - 1 - int'(idx)));
      return shifted[7:0];
   endfunction

endpackage

// File: rtl/ksa_swap_fsm.sv
// RC4 key-scheduling stage: 256 read/read/write/write swap iterations over the shared S-RAM.
// Outputs are registered copies of the decode of the next state, so they stay Moore and glitch-free.
module ksa_swap_fsm
   import rc4_pkg::*;
#(
   parameter int KEY_LENGTH = DEFAULT_KEY_LENGTH,
   parameter int KEY_WIDTH  = 24
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [KEY_WIDTH-1:0] secret_key,
   input  logic [7:0]           q,
   output logic [7:0]           address,
   output logic [7:0]           data,
   output logic                 wren,
   output logic                 rden,
   output logic                 done
);

   localparam logic [7:0] LAST_I    = 8'(S_SIZE - 1);
   localparam logic [7:0] LAST_KIDX = 8'(KEY_LENGTH - 1);

   ksa_state_t           state_q, state_d;
   logic [7:0]           i_q, i_d;
   logic [7:0]           j_q, j_d;
   logic [7:0]           si_q, si_d;
   logic [7:0]           sj_q, sj_d;
   logic [7:0]           kidx_q, kidx_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic [7:0]           address_q, address_d;
   logic [7:0]           data_q, data_d;
   logic                 wren_q, wren_d;
   logic                 rden_q, rden_d;
   logic                 done_q, done_d;
   logic [7:0]           key_byte_s;

   assign key_byte_s = key_byte_select(KEY_MAX_WIDTH'(key_q), kidx_q, KEY_LENGTH);

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      si_d    = si_q;
      sj_d    = sj_q;
      kidx_d  = kidx_q;
      key_d   = key_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               i_d     = 8'd0;
               j_d     = 8'd0;
               kidx_d  = 8'd0;
               key_d   = secret_key;
               state_d = RD_SI;
            end else begin
               state_d = IDLE;
            end
         end
         RD_SI:   state_d = WAIT_SI;
         WAIT_SI: begin
            si_d    = q;
            j_d     = j_q + q + key_byte_s;
            state_d = RD_SJ;
         end
         RD_SJ:   state_d = WAIT_SJ;
         WAIT_SJ: begin
            sj_d    = q;
            state_d = WR_SI;
         end
         WR_SI:   state_d = WR_SJ;
         WR_SJ: begin
            if (i_q == LAST_I) begin
               state_d = DONE;
            end else begin
               i_d     = i_q + 8'd1;
               // i mod KEY_LENGTH tracked by a wrapping counter instead of a divider.
               kidx_d  = (kidx_q == LAST_KIDX) ? 8'd0 : kidx_q + 8'd1;
               state_d = RD_SI;
            end
         end
         DONE: begin
            if (!start) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // RAM-side outputs decoded from the upcoming state and datapath values.
   always_comb begin
      address_d = 8'd0;
      data_d    = 8'd0;
      wren_d    = 1'b0;
      rden_d    = 1'b0;
      done_d    = 1'b0;
      case (state_d)
         RD_SI, WAIT_SI: begin
            address_d = i_d;
            rden_d    = 1'b1;
         end
         RD_SJ, WAIT_SJ: begin
            address_d = j_d;
            rden_d    = 1'b1;
         end
         WR_SI: begin
            address_d = i_d;
            data_d    = sj_d;
            wren_d    = 1'b1;
         end
         WR_SJ: begin
            address_d = j_d;
            data_d    = si_d;
            wren_d    = 1'b1;
         end
         DONE:    done_d = 1'b1;
         default: done_d = 1'b0;
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         i_q       <= 8'd0;
         j_q       <= 8'd0;
         si_q      <= 8'd0;
         sj_q      <= 8'd0;
         kidx_q    <= 8'd0;
         key_q     <= {KEY_WIDTH{1'b0}};
         address_q <= 8'd0;
         data_q    <= 8'd0;
         wren_q    <= 1'b0;
         rden_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         j_q       <= j_d;
         si_q      <= si_d;
         sj_q      <= sj_d;
         kidx_q    <= kidx_d;
         key_q     <= key_d;
         address_q <= address_d;
         data_q    <= data_d;
         wren_q    <= wren_d;
         rden_q    <= rden_d;
         done_q    <= done_d;
      end
   end

   assign address = address_q;
   assign data    = data_q;
   assign wren    = wren_q;
   assign rden    = rden_q;
   assign done    = done_q;

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// Bench for ksa_swap_fsm: behavioural S-RAM, cycle-by-cycle trace model and RC4 KSA golden result.
module tb_ksa_swap_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [23:0] secret_key;
   logic [7:0]  q;
   logic [7:0]  address;
   logic [7:0]  data;
   logic        wren;
   logic        rden;
   logic        done;

   logic [7:0]  mem [256];
   logic [7:0]  addr_r;
   logic        init_req;
   logic [7:0]  gold [256];
   logic [7:0]  wlog_addr [512];
   logic [7:0]  wlog_data [512];

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [23:0] key;
      int          iter;
      int          slot;
      logic [7:0]  exp_addr;
      logic [7:0]  exp_data;
   } tv_t;

   localparam int N_TV = 9;
   tv_t tv [N_TV];

   always #5 clk = ~clk;

   ksa_swap_fsm #(.KEY_LENGTH(3), .KEY_WIDTH(24)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .secret_key (secret_key),
      .q          (q),
      .address    (address),
      .data       (data),
      .wren       (wren),
      .rden       (rden),
      .done       (done)
   );

   // Single-port RAM: registered address, unregistered read data.
   always @(posedge clk) begin
      if (init_req) begin
         for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
      end else if (wren) begin
         mem[address] <= data;
      end
      addr_r <= address;
   end
   assign q = mem[addr_r];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [7:0] kb(input logic [23:0] key, input int idx);
      return key[23 - 8*idx -: 8];
   endfunction

   task automatic compute_gold(input logic [23:0] key);
      logic [7:0] j, t;
      for (int a = 0; a < 256; a++) gold[a] = 8'(a);
      j = 8'd0;
      for (int i = 0; i < 256; i++) begin
         j       = j + gold[i] + kb(key, i % 3);
         t       = gold[i];
         gold[i] = gold[j];
         gold[j] = t;
      end
   endtask

   task automatic check_final(input string name, input logic [23:0] key);
      int nm = 0;
      compute_gold(key);
      for (int a = 0; a < 256; a++) if (mem[a] !== gold[a]) nm++;
      check(name, nm, 0);
   endtask

   task automatic init_mem();
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
   endtask

   // Runs one KSA pass, checking every cycle against the expected 6-phase schedule.
   task automatic run_ksa(input logic [23:0] key, input int toggle_at, input int drop_at,
                          input int abort_at, input string tag);
      logic [7:0] s [256];
      logic [7:0] jm, jn, t, exp_addr, exp_data;
      logic       exp_wren, exp_rden;
      int         n, errs, excl, it, ph;
      string      first;
      for (int a = 0; a < 256; a++) s[a] = 8'(a);
      jm = 8'd0; jn = 8'd0; errs = 0; excl = 0; first = "";
      secret_key = key;
      start      = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rden && n < 20);
      check({tag, "_first_rd"}, rden, 1);
      if (rden) begin
         for (int k = 0; k < 1536; k++) begin
            it = k / 6;
            ph = k % 6;
            if (ph == 0) jn = jm + s[it] + kb(key, it % 3);
            exp_rden = (ph < 4);
            exp_wren = (ph >= 4);
            exp_addr = (ph == 2 || ph == 3 || ph == 5) ? jn : 8'(it);
            exp_data = (ph == 4) ? s[jn] : ((ph == 5) ? s[it] : 8'd0);
            if (rden && wren) excl++;
            if ({address, data, wren, rden, done} !== {exp_addr, exp_data, exp_wren, exp_rden, 1'b0}) begin
               if (errs == 0)
                  first = $sformatf("k=%0d addr=%0h data=%0h wren=%b rden=%b done=%b want %0h %0h %b %b 0",
                                    k, address, data, wren, rden, done, exp_addr, exp_data, exp_wren, exp_rden);
               errs++;
            end
            if (ph >= 4) begin
               wlog_addr[2*it + ph - 4] = address;
               wlog_data[2*it + ph - 4] = data;
            end
            if (ph == 5) begin
               t     = s[it];
               s[it] = s[jn];
               s[jn] = t;
               jm    = jn;
            end
            if (k == toggle_at) secret_key = 24'hFFFFFF;
            if (k == drop_at) start = 1'b0;
            if (k == abort_at) break;
            @(negedge clk);
         end
         check({tag, "_trace"}, errs, 0);
         if (errs != 0) $display("  first deviation: %s", first);
         check({tag, "_excl"}, excl, 0);
         if (abort_at < 0) check({tag, "_done_at_1536"}, {done, wren, rden}, 3'b100);
      end
   endtask

   task automatic table_check(input logic [23:0] key);
      int idx;
      for (int t = 0; t < N_TV; t++) begin
         if (tv[t].key == key) begin
            idx = 2*tv[t].iter + tv[t].slot;
            check($sformatf("wr_%06h_i%0d_s%0d_addr", key, tv[t].iter, tv[t].slot), wlog_addr[idx], tv[t].exp_addr);
            check($sformatf("wr_%06h_i%0d_s%0d_data", key, tv[t].iter, tv[t].slot), wlog_data[idx], tv[t].exp_data);
         end
      end
   endtask

   initial begin
      int herr;
      tv[0] = '{24'h000249, 1, 0, 8'd1,  8'd3};
      tv[1] = '{24'h000249, 1, 1, 8'd3,  8'd1};
      tv[2] = '{24'h000249, 2, 0, 8'd2,  8'd78};
      tv[3] = '{24'h000249, 2, 1, 8'd78, 8'd2};
      tv[4] = '{24'h000000, 0, 0, 8'd0,  8'd0};
      tv[5] = '{24'h000000, 0, 1, 8'd0,  8'd0};
      tv[6] = '{24'h000000, 1, 0, 8'd1,  8'd1};
      tv[7] = '{24'h000000, 2, 0, 8'd2,  8'd3};
      tv[8] = '{24'h000000, 2, 1, 8'd3,  8'd2};

      reset = 1'b0; start = 1'b0; secret_key = 24'h0; init_req = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {address, data, wren, rden, done}, 19'd0);
      reset = 1'b1;
      @(negedge clk);
      check("idle_outputs", {address, data, wren, rden, done}, 19'd0);

      // Key 000249, then hold start high in DONE and release it.
      init_mem();
      run_ksa(24'h000249, -1, -1, -1, "a");
      table_check(24'h000249);
      check_final("a_final", 24'h000249);
      herr = 0;
      repeat (20) begin
         @(negedge clk);
         if (!done || wren || rden) herr++;
      end
      check("a_hold_done", herr, 0);
      start = 1'b0;
      @(negedge clk);
      check("a_done_drop", done, 0);

      // All-zero key: fresh run from i=0, j=0 including the i==j iterations.
      init_mem();
      run_ksa(24'h000000, -1, -1, -1, "b");
      table_check(24'h000000);
      check_final("b_final", 24'h000000);
      check("b_s0_kept", mem[0], 8'd0);
      start = 1'b0;
      repeat (2) @(negedge clk);

      // Key changes and start drops mid-run must not disturb the pass.
      init_mem();
      run_ksa(24'h5A17C3, 700, 900, -1, "c");
      check_final("c_final", 24'h5A17C3);
      @(negedge clk);
      check("c_idle_after", {done, wren, rden}, 3'b000);

      // Reset during WR_SI of i=10, then re-init and full rerun.
      init_mem();
      run_ksa(24'h123456, -1, -1, 64, "d");
      reset = 1'b0;
      start = 1'b0;
      #1;
      check("d_async_reset", {address, data, wren, rden, done}, 19'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("d_idle_after_reset", {address, wren, rden, done}, 11'd0);
      init_mem();
      run_ksa(24'h123456, -1, -1, -1, "e");
      check_final("e_final", 24'h123456);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ksa_swap_fsm.md
Name: ksa_swap_fsm

Overview:
- RC4 key-scheduling (KSA) stage. Runs after the S-RAM initialiser has written S[i]=i for i=0..255.
- Reads S back and performs 256 swap iterations: j = j + S[i] + key[i mod KEY_LENGTH]; swap S[i], S[j].
- Sits between the initialiser and the PRGA/decrypt stage, and shares the single-port 256x8 S-RAM through the top-level mux.

Parameters:
- KEY_LENGTH, 3, number of key bytes.
- KEY_WIDTH, 24, secret key width; must equal 8*KEY_LENGTH.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low
- start  input  1  level; high = S-RAM initialised, begin KSA
- secret_key  input  KEY_WIDTH  key; byte 0 = bits [KEY_WIDTH-1 -: 8], big-endian
- q  input  8  S-RAM read data
- address  output  8  S-RAM address
- data  output  8  S-RAM write data
- wren  output  1  S-RAM write enable
- rden  output  1  S-RAM read enable
- done  output  1  KSA complete

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset values: state=IDLE, i=0, j=0, si=0, sj=0, key register=0; address=0, data=0, wren=0, rden=0, done=0.
- RAM contract: address registered at the clock edge; q reflects the registered address during the following cycle (no output register).
- All outputs are decoded from state and datapath registers only (Moore); no q-to-output combinational path.
- States and outputs:
  - IDLE: wren=0, rden=0. On start=1: i<=0, j<=0, key register<=secret_key, go to RD_SI.
  - RD_SI: address=i, rden=1. Go to WAIT_SI.
  - WAIT_SI: address=i, rden=1. At the edge: si<=q; j<=j+q+keybyte(i mod KEY_LENGTH), mod 256. Go to RD_SJ.
  - RD_SJ: address=j (new j), rden=1. Go to WAIT_SJ.
  - WAIT_SJ: address=j, rden=1. At the edge: sj<=q. Go to WR_SI.
  - WR_SI: address=i, data=sj, wren=1. Go to WR_SJ.
  - WR_SJ: address=j, data=si, wren=1. If i==255 go to DONE; else i<=i+1 and go to RD_SI.
  - DONE: done=1, wren=0. When start=0, go to IDLE (done=0). While start stays high, hold DONE.
- Timing: 6 cycles per iteration, 1536 cycles from the first RD_SI to entering DONE.
- Arithmetic is 8-bit with wrap. i mod KEY_LENGTH is held in a separate counter that resets to 0 when it would reach KEY_LENGTH; no divider.
- Boundary cases:
  - i==j: both writes target the same address; the second write (si) leaves S unchanged, which is correct.
  - i==255: no increment wrap; exit to DONE.
  - secret_key changes after start are ignored until the next IDLE->RD_SI transition.
  - start dropping mid-run is ignored; the run completes.
  - Reset mid-run returns immediately to IDLE with wren=0. S-RAM is then partially shuffled, and the initialiser must rerun before start is reasserted.
- Only one of wren and rden is high in any cycle.

Decomposition:
- Shared package rc4_pkg holds:
  - ksa_state_t enum (IDLE, RD_SI, WAIT_SI, RD_SJ, WAIT_SJ, WR_SI, WR_SJ, DONE)
  - S_SIZE=256
  - DEFAULT_KEY_LENGTH=3
  - key_byte_select function (index -> byte slice)
- No sub-module needed. Keep the FSM and datapath in one file; the key-byte mux stays a package function.

Test Plan:
- Bench pre-loads identity S, key=24'h000249, pulses start. Required after run: S[1]=3, S[3]=1, S[2]=78, S[78]=2 (as of i=2); done asserts exactly 1536 cycles after the first RD_SI. Full final S is checked against the bench golden model.
- key=24'h000000 with identity S: final S matches the golden model; no cycle has wren and rden both high; address equals i in RD/WAIT_SI and WR_SI.
- i==j case, key=24'h000000: at i=0 the bench sees both writes to address 0 with data 0; S[0] remains 0 after the iteration.
- Reset asserted during WR_SI at i=10: outputs are 0 immediately (asynchronous); after release the FSM sits in IDLE and done=0. Re-init plus start gives the correct golden result.
- Handshake: hold start=1 after done. Done stays 1 and there are no further RAM accesses. Drop start: done=0 the next cycle. Reassert start with a new key: a fresh run starts from i=0, j=0.
- secret_key toggled to 24'hFFFFFF mid-run: final S still matches the key latched at start.
